// File: rtl/mem_dump_if.sv
// mem_dump_if: dump request, memory read port and UART byte handshake of mem_dump_ctrl.
interface mem_dump_if #(parameter int BYTE_ADDR_WIDTH = 6);
    localparam int WA = BYTE_ADDR_WIDTH - 2;
    logic          start;
    logic [WA-1:0] start_addr;
    logic [WA:0]   word_count;
    logic          rd_en;
    logic [WA-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;
    modport master (
        input  start, start_addr, word_count, rd_data, tx_ready,
        output rd_en, rd_addr, tx_data, tx_valid, busy, done
    );
    modport slave (
        output start, start_addr, word_count, rd_data, tx_ready,
        input  rd_en, rd_addr, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: streams a range of 32-bit memory words out as little-endian bytes over a valid/ready link.
// Define MEM_DUMP_CHECKSUM_EN to append one byte holding the mod-256 sum of all data bytes.
module mem_dump_ctrl #(parameter int BYTE_ADDR_WIDTH = 6) (
    input logic        clk,
    input logic        rst,
    mem_dump_if.master bus
);
    localparam int WA = BYTE_ADDR_WIDTH - 2;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] SEND    = 3'd3;
    localparam logic [2:0] FIN     = 3'd5;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam logic [2:0] CHKSUM  = 3'd4;
    logic [7:0]  sum;
`endif
    logic [2:0]  state;
    logic [WA:0] cnt;
    logic [1:0]  idx;
    logic [31:0] word_buf;
    logic [31:0] shifted;
    logic        xfer;
    logic        last_word;
    assign xfer      = bus.tx_valid && bus.tx_ready;
    assign last_word = cnt == (WA+1)'(1);
    assign shifted   = word_buf >> {idx + 2'd1, 3'b000};
    // rd_addr doubles as the running word address; it only matters while rd_en is high
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.rd_en    <= 1'b0;
            bus.rd_addr  <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            word_buf   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bus.rd_addr <= bus.start_addr;
                    cnt         <= bus.word_count;
                    bus.busy    <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum         <= '0;
`endif
                    if (bus.word_count == '0) begin
                        state    <= FIN;
                        bus.done <= 1'b1;
                    end else begin
                        state     <= READ;
                        bus.rd_en <= 1'b1;
                    end
                end
                READ: begin
                    bus.rd_en <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    word_buf     <= bus.rd_data;
                    idx          <= '0;
                    bus.tx_data  <= bus.rd_data[7:0];
                    bus.tx_valid <= 1'b1;
                    state        <= SEND;
                end
                SEND: if (xfer) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum <= sum + bus.tx_data;
`endif
                    if (idx == 2'd3) begin
                        bus.tx_valid <= 1'b0;
                        cnt          <= cnt - (WA+1)'(1);
                        bus.rd_addr  <= bus.rd_addr + WA'(1);
                        if (!last_word) begin
                            state     <= READ;
                            bus.rd_en <= 1'b1;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            state <= CHKSUM;
`else
                            state    <= FIN;
                            bus.done <= 1'b1;
`endif
                        end
                    end else begin
                        idx         <= idx + 2'd1;
                        bus.tx_data <= shifted[7:0];
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                // one idle cycle after the last data byte, then the sum goes out under the same handshake
                CHKSUM: if (!bus.tx_valid) begin
                    bus.tx_valid <= 1'b1;
                    bus.tx_data  <= sum;
                end else if (bus.tx_ready) begin
                    bus.tx_valid <= 1'b0;
                    state        <= FIN;
                    bus.done     <= 1'b1;
                end
`endif
                FIN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb_mem_dump_ctrl: directed dumps checked against a queue model of expected bytes and read addresses.
module tb_mem_dump_ctrl;
    localparam int BAW = 6;
    localparam int WA  = BAW - 2;
    localparam int MW  = 2**WA;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int ready_mode = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0, done_cyc = 0, tv_cnt = 0, first_tv = -1, rd_cnt = 0, start_cyc = 0;
    logic prev_stall = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_data = '0;
    logic [31:0] mem [MW];
    logic [7:0] exp_tx[$], tx_log[$];
    logic [WA-1:0] exp_rd[$], rd_log[$];

    mem_dump_if #(.BYTE_ADDR_WIDTH(BAW)) bus();
    mem_dump_ctrl #(.BYTE_ADDR_WIDTH(BAW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    assign bus.tx_ready = (ready_mode == 0) || (cyc % 3 == 0);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare process: every non-reset cycle, outputs against the expected byte/address queues
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done) check("busy_after_done", bus.busy, 0);
            if (prev_stall) begin
                check("hold_valid", bus.tx_valid, 1);
                check("hold_data", bus.tx_data, prev_data);
            end
            if (bus.tx_valid) begin
                tv_cnt++;
                if (first_tv < 0) first_tv = cyc;
                check("tx_expected", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) check("tx_model", bus.tx_data, exp_tx[0]);
                if (bus.tx_ready) begin
                    tx_log.push_back(bus.tx_data);
                    if (exp_tx.size() > 0) void'(exp_tx.pop_front());
                end
            end
            if (bus.rd_en) begin
                rd_cnt++;
                rd_log.push_back(bus.rd_addr);
                check("rd_expected", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) check("rd_model", bus.rd_addr, exp_rd.pop_front());
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            prev_done  = bus.done;
        end else begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end
    end

    function automatic logic [31:0] pack(int base);
        logic [31:0] w = '0;
        for (int b = 0; b < 4; b++)
            if (base + b < tx_log.size()) w[8*b +: 8] = tx_log[base + b];
        return w;
    endfunction

    task automatic dump(int sa, int wc);
        logic [31:0] word;
        for (int w = 0; w < wc; w++) begin
            word = mem[(sa + w) % MW];
            exp_rd.push_back(WA'((sa + w) % MW));
            for (int b = 0; b < 4; b++) exp_tx.push_back(word[8*b +: 8]);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        if (wc > 0) begin
            logic [7:0] s;
            s = '0;
            foreach (exp_tx[i]) s += exp_tx[i];
            exp_tx.push_back(s);
        end
`endif
        tx_log.delete();
        rd_log.delete();
        done_cnt = 0; tv_cnt = 0; first_tv = -1; rd_cnt = 0;
        bus.start = 1'b1;
        bus.start_addr = WA'(sa);
        bus.word_count = (WA+1)'(wc);
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", done_cnt > 0, 1);
        @(posedge clk); #1;
        check("tx_model_drained", exp_tx.size(), 0);
        check("rd_model_drained", exp_rd.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.word_count = '0;
        for (int i = 0; i < MW; i++) mem[i] = 32'h1122_3344 + 32'h0101_0101 * i;
        mem[0] = 32'h0403_0201;
        mem[1] = 32'h0807_0605;
        mem[3] = 32'hDDCC_BBAA;
        mem[9] = 32'h7856_3412;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single word, always ready
        dump(3, 1);
        wait_done(40);
        check("t1_count", tx_log.size(), 4 + CK);
        check("t1_bytes", pack(0), 32'hDDCC_BBAA);
        check("t1_rd_cycles", rd_cnt, 1);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_latency", first_tv - start_cyc, 3);
        check("t1_done_cycle", done_cyc - start_cyc, CK ? 9 : 7);

        // ready one cycle in three, plus a start while busy that must be ignored
        ready_mode = 1;
        dump(3, 1);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_addr = '0; bus.word_count = 5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(80);
        check("t2_count", tx_log.size(), 4 + CK);
        check("t2_bytes", pack(0), 32'hDDCC_BBAA);
        check("t2_rd_cycles", rd_cnt, 1);
        check("t2_done_pulses", done_cnt, 1);
        ready_mode = 0;

        // address wrap
        dump(15, 2);
        wait_done(60);
        check("t3_rd_count", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check("t3_rd_first", rd_log[0], 15);
            check("t3_rd_second", rd_log[1], 0);
        end

        // empty dump
        dump(7, 0);
        wait_done(10);
        check("t4_done_cycle", done_cyc - start_cyc, 1);
        check("t4_tx_valid_cycles", tv_cnt, 0);
        check("t4_rd_cycles", rd_cnt, 0);
        check("t4_done_pulses", done_cnt, 1);

        // two words, checksum byte when enabled
        dump(0, 2);
        wait_done(60);
        check("t5_count", tx_log.size(), 8 + CK);
        check("t5_word1", pack(4), 32'h0807_0605);
`ifdef MEM_DUMP_CHECKSUM_EN
        if (tx_log.size() == 9) check("t5_checksum", tx_log[8], 8'h24);
`endif

        // whole memory from the middle
        dump(10, MW);
        wait_done(400);
        check("t6_count", tx_log.size(), 4 * MW + CK);
        check("t6_rd_cycles", rd_cnt, MW);
        if (rd_log.size() > 6) check("t6_wrap_addr", rd_log[6], 0);

        // reset while the second byte of a three-word dump is on the link
        dump(5, 3);
        begin
            int n = 0;
            while (!(tx_log.size() == 1 && bus.tx_valid) && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("t7_at_byte2", tx_log.size(), 1);
        rst = 1'b1;
        bus.start = 1'b1; bus.start_addr = 2; bus.word_count = 1;
        exp_tx.delete();
        exp_rd.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        check("t7_tx_valid", bus.tx_valid, 0);
        check("t7_busy", bus.busy, 0);
        @(posedge clk); #1;
        check("t7_no_done", done_cnt, 0);
        check("t7_idle", bus.busy, 0);
        dump(9, 1);
        wait_done(40);
        check("t7_bytes", pack(0), 32'h7856_3412);
        check("t7_done_pulses", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
